stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
- Stopwatch timekeeping stage in mm:ss.cc format. It sits directly downstream of the flip-flop/debounce front end, which delivers the button levels start_stop, lap and clear.
- Contains an internal prescaler, a run/pause control FSM, a cascaded BCD counter and a lap snapshot register.
- Its BCD digit outputs feed the display driver.

Parameters:
- TICK_DIV, 500000, clk cycles per 1/100 s tick (50 MHz -> 100 Hz); legal range >= 2.
- MAX_MIN, 59, highest minute value before saturation; legal range 1..99.

Ports:
- clk  input  1  system clock; every register samples on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start_stop  input  1  button level, already debounced; each rising edge counts as one press.
- lap  input  1  button level; each rising edge counts as one press.
- clear  input  1  button level; each rising edge counts as one press.
- cs_ones, cs_tens  output  4 each  displayed centisecond digits (BCD).
- sec_ones, sec_tens  output  4 each  displayed second digits (BCD).
- min_ones, min_tens  output  4 each  displayed minute digits (BCD).
- running  output  1  high while in RUN.
- lap_active  output  1  high while the display shows the frozen lap snapshot.
- overflow  output  1  sticky; set on saturation, cleared only by clear or reset.

Behaviour:
- Reset (reset=0, asynchronous): the following all go to 0.
  - state goes to IDLE.
  - All live and lap digits, prescaler and edge-detect history registers.
  - running, lap_active, overflow.
- Edge detection: each input has a registered previous value. A press is input=1 while the previous value=0. A held level counts as exactly one press. A press is acted on at the same edge at which it is detected.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN, but only when overflow=0; otherwise the press is ignored.
  - clear in any state -> IDLE. Live count, prescaler, lap_active and overflow all go to 0.
- Simultaneous presses:
  - clear has priority over start_stop and lap in the same cycle.
  - start_stop and lap together in RUN: lap is processed first (snapshot of the current count), then the state goes to PAUSE.
- running is registered and equals (state==RUN). It goes high on the edge that samples the start_stop press.
- Prescaler:
  - Counts 0..TICK_DIV-1, in RUN only.
  - tick is high when prescaler==TICK_DIV-1 and state==RUN; the prescaler then wraps to 0.
  - Holds its value in PAUSE, so the partial period is kept on resume. Zeroed in IDLE.
  - First tick occurs TICK_DIV cycles after the edge that entered RUN from IDLE.
- BCD cascade, advanced on tick:
  - cs_ones 0..9, carry to cs_tens 0..9.
  - Carry to sec_ones 0..9, then sec_tens 0..5.
  - Carry to minutes 00..MAX_MIN, held as two BCD digits.
  - No digit ever holds a value above 9 (tens-of-seconds never above 5).
- Saturation: on a tick while the count is MAX_MIN:59.99:
  - the count holds;
  - overflow is set to 1;
  - state goes to PAUSE.
- Lap:
  - In RUN, a lap press with lap_active=0 copies the live count into the lap register (value before any same-cycle tick) and sets lap_active=1.
  - In RUN, a lap press with lap_active=1 clears lap_active.
  - In PAUSE or IDLE, a lap press clears lap_active if it is set; otherwise it is ignored.
  - Live counting continues regardless of lap_active.
- Display outputs: lap register when lap_active=1, live count otherwise. The mux is combinational from registers and adds no extra latency.
- Reset asserted mid-count: everything is cleared immediately (asynchronous). After release, counting restarts only after a new start_stop press.

Decomposition:
- stopwatch_pkg contains:
  - typedef enum sw_state_t {SW_IDLE, SW_RUN, SW_PAUSE};
  - typedef bcd_t (logic [3:0]);
  - typedef struct sw_time_t with six bcd_t fields;
  - constant SW_ZERO_TIME.
- Sub-module bcd_digit: one BCD digit with a parameterised limit.
  - Inputs: clk, reset, en, clr.
  - Outputs: q, carry. carry = en && q==limit.
  - Instantiated six times; the minute pair is chained with a combined-limit check against MAX_MIN.

Test Plan (TICK_DIV=4 unless stated):
- Reset/start: release reset, pulse start_stop at cycle 10 -> running=1 from cycle 11; digits reach 00:00.01 after 4 more cycles; 00:01.00 after 400 cycles of RUN.
- Carry chain: run for 6000 ticks -> 01:00.00; check sec_tens never exceeds 5 and cs wraps 99->00 with a seconds carry.
- Pause/resume: pause at prescaler=2, wait 50 cycles -> digits and prescaler frozen; resume -> next tick after exactly 1 cycle.
- Lap: lap at 00:00.37 -> display frozen at 00:00.37 while live count advances; lap again at live 00:00.50 -> display shows live 00:00.50 at once.
- Saturation (MAX_MIN=1): run to 01:59.99 plus one tick -> count holds, overflow=1, running=0; start_stop ignored; clear -> 00:00.00, overflow=0, IDLE.
- Priority/async:
  - clear and start_stop in the same cycle during RUN -> IDLE, running=0.
  - start_stop held high 20 cycles -> exactly one transition.
  - reset driven low mid-cycle -> outputs zero before the next clk edge.

Source files
------------

// File: rtl/stopwatch_time_counter_pkg.sv
// Shared types and helpers for the stopwatch timekeeping stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_RUN,
        SW_PAUSE
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
        bcd_t cs_tens;
        bcd_t cs_ones;
    } sw_time_t;

    localparam sw_time_t SW_ZERO_TIME = '0;

    // Two-digit BCD encoding of a 0..99 value, used for the minute limit.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One BCD counter digit that wraps to 0 after LIMIT and flags a carry on that step.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t LIMIT = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LIMIT) ? '0 : q + 4'd1;
        end
    end

    assign carry = en && (q == LIMIT);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch mm:ss.cc timekeeper: prescaler, run/pause FSM, BCD cascade and lap snapshot.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int unsigned PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]  MAX_MIN_BCD = to_bcd2(MAX_MIN);

    logic ss_q, lap_q, clr_q;
    logic ss_press, lap_press, clr_press;

    sw_state_t state, next_state;

    logic [PW-1:0] presc;
    logic          tick;
    logic          at_max;
    logic          cnt_en;
    logic          sat_tick;

    sw_time_t live;
    sw_time_t lap_time;
    sw_time_t disp;

    logic c_cs_ones, c_cs_tens, c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_q  <= 1'b0;
            lap_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ss_q  <= start_stop;
            lap_q <= lap;
            clr_q <= clear;
        end
    end

    assign ss_press  = start_stop && !ss_q;
    assign lap_press = lap && !lap_q;
    assign clr_press = clear && !clr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SW_IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == SW_RUN);
        end
    end

    always_comb begin
        next_state = state;
        if (clr_press) begin
            next_state = SW_IDLE;
        end else begin
            unique case (state)
                SW_IDLE:  if (ss_press) next_state = SW_RUN;
                SW_RUN:   if (ss_press || sat_tick) next_state = SW_PAUSE;
                SW_PAUSE: if (ss_press && !overflow) next_state = SW_RUN;
                default:  next_state = SW_IDLE;
            endcase
        end
    end

    // Prescaler advances on every RUN cycle, including the one that leaves RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (clr_press || state == SW_IDLE) begin
            presc <= '0;
        end else if (state == SW_RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    assign tick = (state == SW_RUN) && (presc == PRESC_LAST);

    assign at_max = ({live.min_tens, live.min_ones} == MAX_MIN_BCD) &&
                    (live.sec_tens == 4'd5) && (live.sec_ones == 4'd9) &&
                    (live.cs_tens == 4'd9) && (live.cs_ones == 4'd9);

    assign cnt_en   = tick && !at_max;
    // A carry out of the minute tens would mean the limit check was bypassed; treat it as saturation too.
    assign sat_tick = (tick && at_max) || c_min_tens;

    bcd_digit #(.LIMIT(4'd9)) u_cs_ones (
        .clk(clk), .reset(reset), .en(cnt_en), .clr(clr_press),
        .q(live.cs_ones), .carry(c_cs_ones)
    );

    bcd_digit #(.LIMIT(4'd9)) u_cs_tens (
        .clk(clk), .reset(reset), .en(c_cs_ones), .clr(clr_press),
        .q(live.cs_tens), .carry(c_cs_tens)
    );

    bcd_digit #(.LIMIT(4'd9)) u_sec_ones (
        .clk(clk), .reset(reset), .en(c_cs_tens), .clr(clr_press),
        .q(live.sec_ones), .carry(c_sec_ones)
    );

    bcd_digit #(.LIMIT(4'd5)) u_sec_tens (
        .clk(clk), .reset(reset), .en(c_sec_ones), .clr(clr_press),
        .q(live.sec_tens), .carry(c_sec_tens)
    );

    bcd_digit #(.LIMIT(4'd9)) u_min_ones (
        .clk(clk), .reset(reset), .en(c_sec_tens), .clr(clr_press),
        .q(live.min_ones), .carry(c_min_ones)
    );

    bcd_digit #(.LIMIT(4'd9)) u_min_tens (
        .clk(clk), .reset(reset), .en(c_min_ones), .clr(clr_press),
        .q(live.min_tens), .carry(c_min_tens)
    );

    // The lap snapshot takes the pre-tick count, since live is still the old value here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_time   <= SW_ZERO_TIME;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else if (clr_press) begin
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (sat_tick) begin
                overflow <= 1'b1;
            end
            if (lap_press) begin
                if (state == SW_RUN && !lap_active) begin
                    lap_time   <= live;
                    lap_active <= 1'b1;
                end else begin
                    lap_active <= 1'b0;
                end
            end
        end
    end

    assign disp = lap_active ? lap_time : live;

    assign cs_ones  = disp.cs_ones;
    assign cs_tens  = disp.cs_tens;
    assign sec_ones = disp.sec_ones;
    assign sec_tens = disp.sec_tens;
    assign min_ones = disp.min_ones;
    assign min_tens = disp.min_tens;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed table, long carry/saturation run and random stimulus vs a centisecond model.
module tb_stopwatch_time_counter;

    localparam int TD   = 4;
    localparam int MM   = 1;
    localparam int MAXC = MM * 6000 + 5999;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
    logic       running, lap_active, overflow;

    stopwatch_time_counter #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
        .clk(clk), .reset(reset),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .cs_ones(cs_ones), .cs_tens(cs_tens),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: time kept as a plain centisecond total; mode 0=idle 1=run 2=pause.
    int m_mode, m_presc, m_time, m_lap;
    bit m_lapact, m_ovf;
    bit p_s, p_l, p_c;

    typedef struct {
        bit          s;
        bit          l;
        bit          c;
        int          n;
        logic [23:0] dig;
        bit          run;
        bit          la;
        bit          ov;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(bit s, bit l, bit c, int n, logic [23:0] dig, bit run, bit la, bit ov);
        vec_t v;
        v.s = s; v.l = l; v.c = c; v.n = n; v.dig = dig; v.run = run; v.la = la; v.ov = ov;
        return v;
    endfunction

    function automatic logic [26:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones, running, lap_active, overflow};
    endfunction

    function automatic logic [26:0] model_vec();
        int d, mins, secs, cc;
        d    = m_lapact ? m_lap : m_time;
        mins = d / 6000;
        secs = (d / 100) % 60;
        cc   = d % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(cc / 10), 4'(cc % 10), (m_mode == 1), m_lapact, m_ovf};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_presc = 0; m_time = 0; m_lap = 0;
        m_lapact = 0; m_ovf = 0;
        p_s = 0; p_l = 0; p_c = 0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit c);
        bit sp, lp, cp, tk, sat;
        int nm;
        sp  = s && !p_s;
        lp  = l && !p_l;
        cp  = c && !p_c;
        tk  = (m_mode == 1) && (m_presc == TD - 1);
        sat = 0;
        if (cp) begin
            m_mode = 0; m_presc = 0; m_time = 0; m_lapact = 0; m_ovf = 0;
        end else begin
            if (lp) begin
                if (m_mode == 1 && !m_lapact) begin
                    m_lap = m_time;
                    m_lapact = 1;
                end else begin
                    m_lapact = 0;
                end
            end
            nm = m_mode;
            if (m_mode == 1) begin
                m_presc = tk ? 0 : m_presc + 1;
                if (tk) begin
                    if (m_time == MAXC) sat = 1;
                    else m_time = m_time + 1;
                end
            end
            case (m_mode)
                0: if (sp) nm = 1;
                1: if (sp || sat) nm = 2;
                2: if (sp && !m_ovf) nm = 1;
                default: nm = 0;
            endcase
            if (sat) m_ovf = 1;
            m_mode = nm;
        end
        p_s = s; p_l = l; p_c = c;
    endtask

    task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit l, input bit c);
        @(negedge clk);
        start_stop = s;
        lap        = l;
        clear      = c;
        @(posedge clk);
        model_step(s, l, c);
        #1;
    endtask

    bit range_bad;
    bit rs, rl, rc;

    initial begin
        reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        model_reset();
        range_bad = 0;

        tbl[0]  = mk(0, 0, 0,   5, 24'h000000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0,   1, 24'h000000, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0,   4, 24'h000001, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 396, 24'h000100, 1, 0, 0);
        tbl[4]  = mk(0, 1, 0,   1, 24'h000100, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0,  40, 24'h000100, 1, 1, 0);
        tbl[6]  = mk(0, 1, 0,   1, 24'h000110, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0,   1, 24'h000110, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0,  50, 24'h000110, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0,   1, 24'h000110, 1, 0, 0);
        tbl[10] = mk(0, 0, 0,   1, 24'h000111, 1, 0, 0);
        tbl[11] = mk(1, 1, 0,   1, 24'h000111, 0, 1, 0);
        tbl[12] = mk(0, 0, 0,   3, 24'h000111, 0, 1, 0);
        tbl[13] = mk(0, 1, 0,   1, 24'h000111, 0, 0, 0);
        tbl[14] = mk(1, 0, 0,   1, 24'h000111, 1, 0, 0);
        tbl[15] = mk(1, 0, 0,  19, 24'h000116, 1, 0, 0);
        tbl[16] = mk(0, 0, 0,   1, 24'h000116, 1, 0, 0);
        tbl[17] = mk(1, 0, 1,   1, 24'h000000, 0, 0, 0);
        tbl[18] = mk(0, 0, 0,   2, 24'h000000, 0, 0, 0);
        tbl[19] = mk(0, 1, 0,   1, 24'h000000, 0, 0, 0);
        tbl[20] = mk(0, 0, 0,   1, 24'h000000, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 27'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].s, tbl[i].l, tbl[i].c);
            check($sformatf("tbl%0d", i), dut_vec(), {tbl[i].dig, tbl[i].run, tbl[i].la, tbl[i].ov});
            check($sformatf("tbl%0d_model", i), dut_vec(), model_vec());
        end

        // Long run through the minute carry and on to saturation.
        cyc(1, 0, 0);
        for (int k = 0; k < 24000; k++) begin
            cyc(0, 0, 0);
            if (sec_tens > 4'd5 || sec_ones > 4'd9 || cs_tens > 4'd9 || cs_ones > 4'd9 ||
                min_ones > 4'd9 || min_tens > 4'd9) range_bad = 1;
            if (k % 8 == 0) check("carry_run", dut_vec(), model_vec());
        end
        check("min_rollover", dut_vec(), {24'h010000, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 23996; k++) begin
            cyc(0, 0, 0);
            if (sec_tens > 4'd5 || sec_ones > 4'd9 || cs_tens > 4'd9 || cs_ones > 4'd9 ||
                min_ones > 4'd9 || min_tens > 4'd9) range_bad = 1;
            if (k % 8 == 0) check("sat_run", dut_vec(), model_vec());
        end
        check("digit_range", {26'h0, range_bad}, 27'h0);
        check("pre_sat", dut_vec(), {24'h015999, 1'b1, 1'b0, 1'b0});
        repeat (4) cyc(0, 0, 0);
        check("sat", dut_vec(), {24'h015999, 1'b0, 1'b0, 1'b1});
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("ss_ignored", dut_vec(), {24'h015999, 1'b0, 1'b0, 1'b1});
        cyc(0, 0, 1);
        check("clear_sat", dut_vec(), 27'h0);
        cyc(0, 0, 0);

        // Asynchronous reset in the middle of a count.
        cyc(1, 0, 0);
        repeat (30) cyc(0, 0, 0);
        check("pre_async", dut_vec(), model_vec());
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset", dut_vec(), 27'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (10) cyc(0, 0, 0);
        check("no_restart", dut_vec(), 27'h0);

        rs = 0; rl = 0; rc = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 29) == 0) rs = ~rs;
            if ($urandom_range(0, 24) == 0) rl = ~rl;
            rc = ($urandom_range(0, 299) == 0);
            cyc(rs, rl, rc);
            check("rand", dut_vec(), model_vec());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
